// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_pkg
//  Brief    : Shared types and constants for the SDRAM arbiter slice:
//             arbiter FSM state encoding, grant type, refresh period and the
//             saturating pending-refresh update.
//  Revision : 1.0  initial release
// ============================================================================
package sdram_pkg;

  // Refresh interval in microseconds
  localparam int REFRESH_US = 15;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2,
    GNT_REF  = 2'd3
  } gnt_e;

  // Pending-refresh count update: saturates at 3, never underflows, and an
  // increment coinciding with a decrement leaves the count unchanged.
  function automatic logic [1:0] pending_next(input logic [1:0] cur,
                                              input logic       inc,
                                              input logic       dec);
    logic [1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != 2'd3)) begin
      nxt = cur + 2'd1;
    end else if (dec && !inc && (cur != 2'd0)) begin
      nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_refresh_timer
//  Brief    : Free-running refresh down-counter. Each expiry reloads the
//             counter and adds one to a 2-bit saturating pending count; the
//             arbiter consumes pending refreshes through I_dec.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int REFRESH_CYCLES = 720
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_dec,
  output logic [1:0] O_pending
);

  localparam int               CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pending_q, pending_d;
  logic             expire;

  // Count down, reload at zero and account the expiry in the pending count
  always_comb begin
    expire    = (cnt_q == '0);
    cnt_d     = expire ? RELOAD : (cnt_q - CNT_W'(1));
    pending_d = pending_next(pending_q, expire, I_dec);
  end

  // Timer and pending-count registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt_q     <= RELOAD;
      pending_q <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign O_pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbiter
//  Brief    : Shares one SDRAM controller between P0 (CPU) and P1 (DMA/video),
//             inserts periodic auto-refresh and sequences single-word
//             read/write commands on the controller's pulse/busy interface.
//             Build option SDRAM_ARB_FIXED_PRIO_EN: P0 always beats P1
//             (default build: round-robin between the two ports).
//  Revision : 1.0  initial release
// ============================================================================
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int FREQ           = 48_000_000,
  parameter int REFRESH_CYCLES = FREQ / 1_000_000 * REFRESH_US,
  parameter int ADDR_WIDTH     = 23
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_p0_req,
  input  logic                  I_p0_we,
  input  logic [ADDR_WIDTH-1:0] I_p0_addr,
  input  logic [31:0]           I_p0_wdata,
  output logic [31:0]           O_p0_rdata,
  output logic                  O_p0_done,
  input  logic                  I_p1_req,
  input  logic                  I_p1_we,
  input  logic [ADDR_WIDTH-1:0] I_p1_addr,
  input  logic [31:0]           I_p1_wdata,
  output logic [31:0]           O_p1_rdata,
  output logic                  O_p1_done,
  output logic                  O_cmd_read,
  output logic                  O_cmd_write,
  output logic                  O_cmd_refresh,
  output logic [ADDR_WIDTH-1:0] O_address,
  output logic [31:0]           O_data_in,
  input  logic [31:0]           I_data_out,
  input  logic                  I_data_ready,
  input  logic                  I_busy
);

  arb_state_e            state_q, state_d;
  gnt_e                  gnt_q, gnt_d;
  gnt_e                  pick;
  logic                  grant_req;
  logic [1:0]            ref_pending;
  logic                  ref_dec;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  cmd_read_q, cmd_read_d;
  logic                  cmd_write_q, cmd_write_d;
  logic                  cmd_refresh_q, cmd_refresh_d;
  logic                  done0_q, done0_d, done1_q, done1_d;

  sdram_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_refresh (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_dec     (ref_dec),
    .O_pending (ref_pending)
  );

  // A requester is granted only from an idle controller with no refresh owed
  assign grant_req = (state_q == ARB_IDLE) && !I_busy &&
                     (ref_pending == 2'd0) && (pick != GNT_NONE);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // Fixed priority: P0 wins whenever it requests
  always_comb begin
    pick = GNT_NONE;
    if (I_p0_req) begin
      pick = GNT_P0;
    end else if (I_p1_req) begin
      pick = GNT_P1;
    end
  end
`else
  logic rr_last_q, rr_last_d;

  // Round-robin: on contention the port not granted last time wins
  always_comb begin
    pick = GNT_NONE;
    if (I_p0_req && I_p1_req) begin
      pick = rr_last_q ? GNT_P0 : GNT_P1;
    end else if (I_p0_req) begin
      pick = GNT_P0;
    end else if (I_p1_req) begin
      pick = GNT_P1;
    end
  end

  // Remember which port received the most recent grant
  always_comb begin
    rr_last_d = rr_last_q;
    if (grant_req) begin
      rr_last_d = (pick == GNT_P1);
    end
  end

  // Round-robin history register; starts as if P1 went last so P0 leads
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  // Arbiter FSM next-state, command sequencing and data capture
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    cmd_read_d    = 1'b0;
    cmd_write_d   = 1'b0;
    cmd_refresh_d = 1'b0;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    ref_dec       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!I_busy) begin
          if (ref_pending != 2'd0) begin
            gnt_d         = GNT_REF;
            cmd_refresh_d = 1'b1;
            state_d       = ARB_ISSUE;
          end else if (pick == GNT_P0) begin
            gnt_d       = GNT_P0;
            addr_d      = I_p0_addr;
            wdata_d     = I_p0_wdata;
            cmd_write_d = I_p0_we;
            cmd_read_d  = !I_p0_we;
            state_d     = ARB_ISSUE;
          end else if (pick == GNT_P1) begin
            gnt_d       = GNT_P1;
            addr_d      = I_p1_addr;
            wdata_d     = I_p1_wdata;
            cmd_write_d = I_p1_we;
            cmd_read_d  = !I_p1_we;
            state_d     = ARB_ISSUE;
          end
        end
      end
      ARB_ISSUE: begin
        // The command strobe is high during this state only
        ref_dec = (gnt_q == GNT_REF);
        state_d = ARB_WAIT_BUSY;
      end
      ARB_WAIT_BUSY: begin
        if (I_busy) begin
          state_d = ARB_WAIT_DONE;
        end
      end
      ARB_WAIT_DONE: begin
        if (I_data_ready) begin
          if (gnt_q == GNT_P0) rdata0_d = I_data_out;
          if (gnt_q == GNT_P1) rdata1_d = I_data_out;
        end
        if (!I_busy) begin
          done0_d = (gnt_q == GNT_P0);
          done1_d = (gnt_q == GNT_P1);
          gnt_d   = GNT_NONE;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state and output registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q       <= ARB_IDLE;
      gnt_q         <= GNT_NONE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      cmd_read_q    <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_refresh_q <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      cmd_read_q    <= cmd_read_d;
      cmd_write_q   <= cmd_write_d;
      cmd_refresh_q <= cmd_refresh_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
    end
  end

  assign O_cmd_read    = cmd_read_q;
  assign O_cmd_write   = cmd_write_q;
  assign O_cmd_refresh = cmd_refresh_q;
  assign O_address     = addr_q;
  assign O_data_in     = wdata_q;
  assign O_p0_rdata    = rdata0_q;
  assign O_p1_rdata    = rdata1_q;
  assign O_p0_done     = done0_q;
  assign O_p1_done     = done1_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arbiter
//  Brief    : Self-checking bench for sdram_arbiter with a behavioural SDRAM
//             controller (init busy period, pulse/busy handshake, word memory).
//             Build option SDRAM_ARB_FIXED_PRIO_EN changes the expected
//             grant order of the contention test.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int INIT  = 3000;  // controller init busy period (cycles)
  localparam int OPLEN = 6;     // controller busy length per command

  typedef struct {
    int          port;
    bit          we;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [22:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_done, p1_done;
  logic        cmd_read, cmd_write, cmd_refresh;
  logic [22:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_arbiter dut (
    .I_clk         (clk),
    .I_rst_n       (rst_n),
    .I_p0_req      (p0_req),
    .I_p0_we       (p0_we),
    .I_p0_addr     (p0_addr),
    .I_p0_wdata    (p0_wdata),
    .O_p0_rdata    (p0_rdata),
    .O_p0_done     (p0_done),
    .I_p1_req      (p1_req),
    .I_p1_we       (p1_we),
    .I_p1_addr     (p1_addr),
    .I_p1_wdata    (p1_wdata),
    .O_p1_rdata    (p1_rdata),
    .O_p1_done     (p1_done),
    .O_cmd_read    (cmd_read),
    .O_cmd_write   (cmd_write),
    .O_cmd_refresh (cmd_refresh),
    .O_address     (address),
    .O_data_in     (data_in),
    .I_data_out    (data_out),
    .I_data_ready  (data_ready),
    .I_busy        (busy)
  );

  // ---------------- behavioural controller ----------------
  logic [31:0] mem [256];
  int          init_cnt;
  int          op_cnt;
  logic        op_rd;
  logic [22:0] op_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt   <= INIT;
      busy       <= 1'b1;
      op_cnt     <= 0;
      op_rd      <= 1'b0;
      op_addr    <= '0;
      data_ready <= 1'b0;
      data_out   <= '0;
    end else begin
      data_ready <= 1'b0;
      if (init_cnt != 0) begin
        init_cnt <= init_cnt - 1;
        if (init_cnt == 1) busy <= 1'b0;
      end else if (op_cnt != 0) begin
        op_cnt <= op_cnt - 1;
        if (op_cnt == 2 && op_rd) begin
          data_ready <= 1'b1;
          data_out   <= mem[op_addr[9:2]];
        end
        if (op_cnt == 1) busy <= 1'b0;
      end else if (cmd_read || cmd_write || cmd_refresh) begin
        busy    <= 1'b1;
        op_cnt  <= OPLEN;
        op_rd   <= cmd_read;
        op_addr <= address;
        if (cmd_write) mem[address[9:2]] <= data_in;
      end
    end
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          log_type[$];
  logic [22:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          proto_err = 0;
  int          done0_cnt = 0;
  int          done1_cnt = 0;
  logic        prev_cmd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_read || cmd_write || cmd_refresh) begin
        if (busy || prev_cmd || ($countones({cmd_read, cmd_write, cmd_refresh}) != 1))
          proto_err <= proto_err + 1;
        log_type.push_back(cmd_read ? 1 : (cmd_write ? 2 : 3));
        log_addr.push_back(address);
        log_data.push_back(data_in);
        log_cyc.push_back(cyc);
      end
      if (p0_done) done0_cnt <= done0_cnt + 1;
      if (p1_done) done1_cnt <= done1_cnt + 1;
    end
    prev_cmd <= cmd_read || cmd_write || cmd_refresh;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int last_access_idx();
    for (int i = log_type.size() - 1; i >= 0; i--) begin
      if (log_type[i] != 3) return i;
    end
    return -1;
  endfunction

  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [22:0] a, input logic [31:0] wd);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = wd;
    end else begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = wd;
    end
  endtask

  task automatic do_access(input int port, input logic we, input logic [22:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output bit ok, input int max_cyc);
    ok = 1'b0;
    rd = '0;
    set_port(port, 1'b1, we, a, wd);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_done : p1_done) begin
        ok = 1'b1;
        rd = (port == 0) ? p0_rdata : p1_rdata;
        break;
      end
    end
    set_port(port, 1'b0, 1'b0, a, wd);
  endtask

  // Hold a read request for four completions, checking data at each done
  task automatic stream(input int port, input logic [22:0] a, input logic [31:0] exp);
    int n;
    n = 0;
    set_port(port, 1'b1, 1'b0, a, '0);
    for (int i = 0; i < 3000 && n < 4; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_done : p1_done) begin
        n++;
        chk($sformatf("rr_p%0d_rdata", port), (port == 0) ? p0_rdata : p1_rdata, exp);
        if (n == 4) set_port(port, 1'b0, 1'b0, a, '0);
      end
    end
    chk($sformatf("rr_p%0d_dones", port), n, 4);
    set_port(port, 1'b0, 1'b0, a, '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t        vecs[8];
    logic [31:0] rd;
    bit          ok;
    int          idx;
    int          base_cyc;
    int          order[$];
    int          ref_cycles[$];
    int          gap_bad;
    int          d0b;
    int          exp_port;

    vecs[0] = '{0, 1'b1, 23'h000100, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 1'b0, 23'h000100, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 23'h000300, 32'hCAFEF00D, 32'h0};
    vecs[3] = '{1, 1'b0, 23'h000300, 32'h0,        32'hCAFEF00D};
    vecs[4] = '{0, 1'b0, 23'h000200, 32'h0,        32'h11111111};
    vecs[5] = '{0, 1'b1, 23'h000104, 32'h12345678, 32'h0};
    vecs[6] = '{1, 1'b0, 23'h000104, 32'h0,        32'h12345678};
    vecs[7] = '{1, 1'b0, 23'h000100, 32'h0,        32'hDEADBEEF};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {59'd0, cmd_read, cmd_write, cmd_refresh, p0_done, p1_done}, 64'd0);
    chk("rst_address", address, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
    rst_n = 1'b1;

    // Request during controller init: refreshes queue and saturate at 3
    fork
      begin
        do_access(0, 1'b1, 23'h000200, 32'h11111111, rd, ok, INIT + 600);
        chk("init_p0_done", ok, 1);
      end
      begin
        repeat (INIT - 50) @(negedge clk);
        chk("init_pending", dut.ref_pending, 3);
        chk("init_no_cmd", log_type.size(), 0);
      end
    join
    chk("init_log_len", log_type.size() >= 4, 1);
    if (log_type.size() >= 4) begin
      chk("init_cmd0_ref", log_type[0], 3);
      chk("init_cmd1_ref", log_type[1], 3);
      chk("init_cmd2_ref", log_type[2], 3);
      chk("init_cmd3_wr", log_type[3], 2);
      chk("init_cmd3_addr", log_addr[3], 23'h000200);
    end

    // Table-driven single accesses
    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, ok, 2000);
      chk($sformatf("vec%0d_done", i), ok, 1);
      idx = last_access_idx();
      chk($sformatf("vec%0d_cmd", i), (idx >= 0) ? log_type[idx] : 0, vecs[i].we ? 2 : 1);
      if (idx >= 0) chk($sformatf("vec%0d_addr", i), log_addr[idx], vecs[i].addr);
      if (vecs[i].we) begin
        if (idx >= 0) chk($sformatf("vec%0d_wdata", i), log_data[idx], vecs[i].wdata);
      end else begin
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        @(negedge clk);
        chk($sformatf("vec%0d_hold", i), (vecs[i].port == 0) ? p0_rdata : p1_rdata, vecs[i].exp);
      end
    end

    // Simultaneous streams: grant order
    base_cyc = cyc;
    fork
      stream(0, 23'h000100, 32'hDEADBEEF);
      stream(1, 23'h000300, 32'hCAFEF00D);
    join
    for (int i = 0; i < log_type.size(); i++) begin
      if (log_cyc[i] >= base_cyc && log_type[i] != 3)
        order.push_back((log_addr[i] == 23'h000100) ? 0 : 1);
    end
    chk("rr_grants", order.size(), 8);
    for (int k = 0; k < 8 && k < order.size(); k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      exp_port = (k < 4) ? 0 : 1;
`else
      exp_port = k % 2;
`endif
      chk($sformatf("grant%0d_port", k), order[k], exp_port);
    end

    // Idle refresh cadence
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (cmd_refresh) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ref_first_seen", ok, 1);
    base_cyc = cyc;
    repeat (7560) @(negedge clk);
    ref_cycles.push_back(base_cyc);
    for (int i = 0; i < log_type.size(); i++) begin
      if (log_cyc[i] > base_cyc && log_type[i] == 3) ref_cycles.push_back(log_cyc[i]);
    end
    chk("ref_count", ref_cycles.size() - 1, 10);
    gap_bad = 0;
    for (int i = 1; i < ref_cycles.size(); i++) begin
      if ((ref_cycles[i] - ref_cycles[i-1]) < 704 || (ref_cycles[i] - ref_cycles[i-1]) > 736)
        gap_bad++;
    end
    chk("ref_spacing", gap_bad, 0);

    // Reset while a read waits for completion
    set_port(0, 1'b1, 1'b0, 23'h000100, '0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_read) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_read_issued", ok, 1);
    repeat (3) @(negedge clk);
    d0b = done0_cnt;
    rst_n = 1'b0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("abort_strobes", {59'd0, cmd_read, cmd_write, cmd_refresh, p0_done, p1_done}, 64'd0);
    chk("abort_address", address, 0);
    chk("abort_data_in", data_in, 0);
    chk("abort_rdata", {p0_rdata, p1_rdata}, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done0_cnt, d0b);
    do_access(0, 1'b1, 23'h000108, 32'hA5A5A5A5, rd, ok, INIT + 600);
    chk("reinit_wr_done", ok, 1);
    do_access(0, 1'b0, 23'h000108, 32'h0, rd, ok, 2000);
    chk("reinit_rd_done", ok, 1);
    chk("reinit_rd_data", rd, 32'hA5A5A5A5);

    chk("cmd_protocol", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
